// File: rtl/gpiomul_seq_ctrl_if.sv
// Register-bus bundle for the multiply/popcount sequencer: address, level strobes, data both ways,
// plus the one-cycle completion pulse. The master drives the bus and the slave answers it.
interface gpiomul_seq_ctrl_if;
    logic [15:0] saddress;
    logic        srd;
    logic        swr;
    logic [31:0] sdata_in;
    logic [31:0] sdata_out;
    logic        done;

    modport master (output saddress, srd, swr, sdata_in, input sdata_out, done);
    modport slave  (input saddress, srd, swr, sdata_in, output sdata_out, done);
endinterface

// File: rtl/gpiomul_seq_ctrl.sv
// Bus-mapped shift-add multiplier followed by a bit-serial popcount of the product.
// Result lands OP_W+RES_W+2 clocks after the A2 write fires (OP_W+1 on overflow); busy writes are dropped.
module gpiomul_seq_ctrl #(
    parameter int          OP_W    = 24,
    parameter int          RES_W   = 32,
    parameter logic [15:0] ADDR_A1 = 16'h1D8,
    parameter logic [15:0] ADDR_A2 = 16'h1E0,
    parameter logic [15:0] ADDR_W  = 16'h1E8,
    parameter logic [15:0] ADDR_L  = 16'h1F0,
    parameter logic [15:0] ADDR_B  = 16'h1F8
) (
    input  logic              clk,
    input  logic              n_reset,
    gpiomul_seq_ctrl_if.slave bus
);
    localparam int ACC_W  = 2 * OP_W;
    localparam int STEP_W = $clog2((OP_W > RES_W) ? OP_W : RES_W);
    localparam int CNT_W  = $clog2(RES_W + 1);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_CHK, S_CNT, S_DONE} state_t;
    state_t state_q, state_d;

    logic              srd_q, srd_prev_q, swr_q, swr_prev_q;
    logic              rd_fire, wr_fire;
    logic [OP_W-1:0]   a1_q, a1_d, a2_q, a2_d;
    logic [ACC_W-1:0]  acc_q, acc_d, mcand_q, mcand_d;
    logic [RES_W-1:0]  w_q, w_d, wtmp_q, wtmp_d, b_q, b_d;
    logic [CNT_W-1:0]  l_q, l_d, cnt_q, cnt_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [31:0]       rdat_q, rdat_d;
    logic              done_q, done_d;
    logic              unused_sdata;

    // Only the rising edge of a registered strobe counts, so long strobes act once.
    assign rd_fire      = srd_q & ~srd_prev_q;
    assign wr_fire      = swr_q & ~swr_prev_q;
    assign unused_sdata = ^bus.sdata_in[31:OP_W];

    assign bus.sdata_out = rdat_q;
    assign bus.done      = done_q;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= S_IDLE;
            srd_q      <= 1'b0;
            srd_prev_q <= 1'b0;
            swr_q      <= 1'b0;
            swr_prev_q <= 1'b0;
            a1_q       <= '0;
            a2_q       <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            w_q        <= '0;
            wtmp_q     <= '0;
            b_q        <= '0;
            l_q        <= '0;
            cnt_q      <= '0;
            step_q     <= '0;
            rdat_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            srd_q      <= bus.srd;
            srd_prev_q <= srd_q;
            swr_q      <= bus.swr;
            swr_prev_q <= swr_q;
            a1_q       <= a1_d;
            a2_q       <= a2_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            w_q        <= w_d;
            wtmp_q     <= wtmp_d;
            b_q        <= b_d;
            l_q        <= l_d;
            cnt_q      <= cnt_d;
            step_q     <= step_d;
            rdat_q     <= rdat_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a1_d    = a1_q;
        a2_d    = a2_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        w_d     = w_q;
        wtmp_d  = wtmp_q;
        b_d     = b_q;
        l_d     = l_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        rdat_d  = rdat_q;
        done_d  = 1'b0;

        // A write wins over a read firing on the same clock.
        if (wr_fire) begin
            if (state_q == S_IDLE) begin
                if (bus.saddress == ADDR_A1) begin
                    a1_d = bus.sdata_in[OP_W-1:0];
                end else if (bus.saddress == ADDR_A2) begin
                    a2_d    = bus.sdata_in[OP_W-1:0];
                    acc_d   = '0;
                    mcand_d = ACC_W'(a1_q);
                    step_d  = '0;
                    w_d     = '0;
                    l_d     = '0;
                    b_d     = RES_W'(1);
                    state_d = S_MUL;
                end
            end
        end else if (rd_fire) begin
            case (bus.saddress)
                ADDR_A1: rdat_d = 32'(a1_q);
                ADDR_A2: rdat_d = 32'(a2_q);
                ADDR_W:  rdat_d = 32'(w_q);
                ADDR_L:  rdat_d = 32'(l_q);
                ADDR_B:  rdat_d = 32'(b_q);
                default: rdat_d = '0;
            endcase
        end

        case (state_q)
            S_MUL: begin
                if (a2_q[step_q]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d = mcand_q << 1;
                step_d  = step_q + STEP_W'(1);
                if (step_q == STEP_W'(OP_W - 1)) begin
                    step_d  = '0;
                    state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (|acc_q[ACC_W-1:RES_W]) begin
                    b_d     = '1;
                    w_d     = '0;
                    l_d     = '0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wtmp_d  = acc_q[RES_W-1:0];
                    cnt_d   = '0;
                    step_d  = '0;
                    state_d = S_CNT;
                end
            end
            S_CNT: begin
                cnt_d  = cnt_q + CNT_W'(wtmp_q[step_q]);
                step_d = step_q + STEP_W'(1);
                if (step_q == STEP_W'(RES_W - 1)) begin
                    step_d  = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                w_d     = wtmp_q;
                l_d     = cnt_q;
                b_d     = '0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: ;
        endcase
    end
endmodule
